uart_rx_frame_ctrl: RTL and testbench

//  Controller that sits behind the UART byte receiver. It consumes the

---
 rtl/uart_rx_frame_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_uart_rx_frame_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame_ctrl.sv
// Parses SYNC/ADDR/LEN/payload/CHK frames from the UART byte stream, buffers and
// checksum-verifies each one, then replays it as a burst of register writes.
module uart_rx_frame_ctrl #(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         ADDR_W         = 8,
    parameter int         MAX_LEN        = 16,
    parameter int         TIMEOUT_CYCLES = 1000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              frame_ok,
    output logic              frame_err,
    output logic [1:0]        err_code,
    output logic              busy
);

    localparam int CNT_W  = $clog2(MAX_LEN + 1);
    localparam int BUF_AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int TO_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_HUNT,
        S_ADDR,
        S_LEN,
        S_DATA,
        S_CHK,
        S_WRITE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [CNT_W-1:0]  len_q, len_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [7:0]        csum_q, csum_d;
    logic [TO_W-1:0]   to_q, to_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic              frame_ok_q, frame_ok_d;
    logic              frame_err_q, frame_err_d;
    logic [1:0]        err_code_q, err_code_d;
    logic              buf_we;
    logic              timed_out;
    logic [7:0]        buf_q [MAX_LEN];

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        csum_d      = csum_q;
        to_d        = '0;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        frame_ok_d  = 1'b0;
        frame_err_d = 1'b0;
        err_code_d  = 2'b00;
        buf_we      = 1'b0;
        timed_out   = 1'b0;

        // The inter-byte timer only runs while a frame is being received.
        if (state_q inside {S_ADDR, S_LEN, S_DATA, S_CHK}) begin
            if (to_q == TO_LAST) begin
                timed_out = 1'b1;
            end else if (!rx_ready) begin
                to_d = to_q + TO_W'(1);
            end
        end

        if (timed_out) begin
            state_d     = S_HUNT;
            frame_err_d = 1'b1;
            err_code_d  = 2'b11;
        end else begin
            case (state_q)
                S_HUNT: begin
                    if (rx_ready && rx_data == SYNC_BYTE) begin
                        state_d = S_ADDR;
                        csum_d  = 8'h00;
                    end
                end
                S_ADDR: begin
                    if (rx_ready) begin
                        base_d  = ADDR_W'(rx_data);
                        csum_d  = csum_q + rx_data;
                        state_d = S_LEN;
                    end
                end
                S_LEN: begin
                    if (rx_ready) begin
                        if (rx_data == 8'h00 || int'(rx_data) > MAX_LEN) begin
                            state_d     = S_HUNT;
                            frame_err_d = 1'b1;
                            err_code_d  = 2'b01;
                        end else begin
                            len_d   = CNT_W'(rx_data);
                            csum_d  = csum_q + rx_data;
                            cnt_d   = '0;
                            state_d = S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (rx_ready) begin
                        buf_we = 1'b1;
                        csum_d = csum_q + rx_data;
                        cnt_d  = cnt_q + CNT_W'(1);
                        if (cnt_q == len_q - CNT_W'(1)) begin
                            state_d = S_CHK;
                        end
                    end
                end
                S_CHK: begin
                    if (rx_ready) begin
                        if (8'(csum_q + rx_data) == 8'h00) begin
                            // Issue the first write on the same edge to meet the one-cycle latency.
                            state_d    = S_WRITE;
                            wr_en_d    = 1'b1;
                            wr_addr_d  = base_q;
                            wr_data_d  = buf_q[0];
                            frame_ok_d = (len_q == CNT_W'(1));
                            cnt_d      = CNT_W'(1);
                        end else begin
                            state_d     = S_HUNT;
                            frame_err_d = 1'b1;
                            err_code_d  = 2'b10;
                        end
                    end
                end
                S_WRITE: begin
                    if (rx_ready) begin
                        frame_err_d = 1'b1;
                        err_code_d  = 2'b00;
                    end
                    if (cnt_q < len_q) begin
                        wr_en_d    = 1'b1;
                        wr_addr_d  = base_q + ADDR_W'(cnt_q);
                        wr_data_d  = buf_q[cnt_q[BUF_AW-1:0]];
                        frame_ok_d = (cnt_q == len_q - CNT_W'(1));
                        cnt_d      = cnt_q + CNT_W'(1);
                    end else begin
                        state_d = S_HUNT;
                    end
                end
                default: state_d = S_HUNT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_HUNT;
            base_q      <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            csum_q      <= '0;
            to_q        <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
            err_code_q  <= 2'b00;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            csum_q      <= csum_d;
            to_q        <= to_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            frame_ok_q  <= frame_ok_d;
            frame_err_q <= frame_err_d;
            err_code_q  <= err_code_d;
        end
    end

    // Payload store needs no reset; it is always written before being read.
    always_ff @(posedge clk) begin
        if (buf_we) begin
            buf_q[cnt_q[BUF_AW-1:0]] <= rx_data;
        end
    end

    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign frame_ok  = frame_ok_q;
    assign frame_err = frame_err_q;
    assign err_code  = err_code_q;
    assign busy      = (state_q != S_HUNT);

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Scoreboard bench for uart_rx_frame_ctrl: frame-level reference model fills expected
// write/error queues; a negedge monitor pops and compares whatever the DUT emits.
module tb_uart_rx_frame_ctrl;

    localparam int T = 60;
    localparam logic [7:0] SYNC = 8'hA5;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       wr_en;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       frame_ok;
    logic       frame_err;
    logic [1:0] err_code;
    logic       busy;

    uart_rx_frame_ctrl #(
        .SYNC_BYTE(SYNC), .ADDR_W(8), .MAX_LEN(16), .TIMEOUT_CYCLES(T)
    ) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_ready(rx_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .frame_ok(frame_ok), .frame_err(frame_err), .err_code(err_code), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [7:0] addr;
        logic [7:0] data;
        bit         last;
    } wr_t;

    typedef struct {
        int         cyc;
        logic [1:0] code;
    } er_t;

    wr_t wr_exp[$];
    er_t er_exp[$];
    int checks = 0;
    int errors = 0;
    logic [7:0] pay [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every write or error pulse must match the head of its queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (wr_en) begin
                if (wr_exp.size() == 0) begin
                    chk("unexpected_wr", 1, 0);
                end else begin
                    wr_t e;
                    e = wr_exp.pop_front();
                    chk("wr_cycle", cyc, e.cyc);
                    chk("wr_addr", wr_addr, e.addr);
                    chk("wr_data", wr_data, e.data);
                    chk("frame_ok", frame_ok, e.last);
                end
            end else if (frame_ok) begin
                chk("frame_ok_without_wr", 1, 0);
            end
            if (frame_err) begin
                if (er_exp.size() == 0) begin
                    chk("unexpected_err", {30'd0, err_code}, 32'hFF);
                end else begin
                    er_t e;
                    e = er_exp.pop_front();
                    chk("err_cycle", cyc, e.cyc);
                    chk("err_code", err_code, e.code);
                end
            end
        end
    end

    // All driver tasks start and end aligned to a falling edge.
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic gap(input int gmax);
        idle(int'($urandom_range(gmax, 0)));
    endtask

    // k = cycle index in which the DUT's registered response to this byte appears.
    task automatic send(input logic [7:0] b, output int k);
        rx_data  = b;
        rx_ready = 1'b1;
        k        = cyc + 1;
        @(negedge clk);
        rx_ready = 1'b0;
        rx_data  = $urandom_range(255, 0);
    endtask

    task automatic send_frame(input logic [7:0] addr, input int len, input bit bad,
                              input int gmax, output int kchk);
        logic [7:0] sum, c;
        int k;
        sum = addr + 8'(len);
        gap(gmax); send(SYNC, k);
        gap(gmax); send(addr, k);
        gap(gmax); send(8'(len), k);
        for (int i = 0; i < len; i++) begin
            gap(gmax); send(pay[i], k);
            sum = sum + pay[i];
        end
        c = 8'h00 - sum;
        if (bad) c = c + 8'h01;
        gap(gmax); send(c, kchk);
        if (bad) begin
            er_exp.push_back('{kchk, 2'b10});
        end else begin
            for (int i = 0; i < len; i++)
                wr_exp.push_back('{kchk + i, addr + 8'(i), pay[i], (i == len - 1)});
        end
    endtask

    task automatic send_badlen(input logic [7:0] len);
        int k;
        send(SYNC, k);
        gap(2); send(8'($urandom_range(255, 0)), k);
        gap(2); send(len, k);
        er_exp.push_back('{k, 2'b01});
    endtask

    task automatic send_noise(input int n);
        int k;
        logic [7:0] b;
        for (int i = 0; i < n; i++) begin
            b = $urandom_range(255, 0);
            if (b == SYNC) b = 8'h00;
            send(b, k);
        end
    endtask

    task automatic rand_pay(input int len);
        for (int i = 0; i < len; i++) pay[i] = $urandom_range(255, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d expected completion", cyc);
        $fatal(1);
    end

    initial begin
        int k, len, j, p;
        logic [7:0] addr;

        rst      = 1'b1;
        rx_ready = 1'b0;
        rx_data  = 8'h00;
        idle(3);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_frame_ok", frame_ok, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_err_code", err_code, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        idle(2);

        // Two-byte frame to address 0x10.
        pay[0] = 8'h11; pay[1] = 8'h22;
        send_frame(8'h10, 2, 1'b0, 0, k);
        idle(4);

        // Corrupted checksum, then a good frame.
        send_frame(8'h10, 2, 1'b1, 0, k);
        chk("busy_after_badchk", busy, 0);
        send_frame(8'h10, 2, 1'b0, 0, k);
        idle(4);

        // LEN of zero and LEN above the buffer depth.
        send_badlen(8'h00);
        send_badlen(8'h11);
        idle(1);
        chk("busy_after_badlen", busy, 0);

        // Truncated frame followed by silence.
        send(SYNC, k);
        chk("busy_in_frame", busy, 1);
        send(8'hFF, k);
        send(8'h01, k);
        send(8'h55, k);
        er_exp.push_back('{k + T, 2'b11});
        idle(T - 2);
        chk("busy_before_timeout", busy, 1);
        idle(4);
        chk("busy_after_timeout", busy, 0);

        // Noise, then a frame whose addresses wrap past 0xFF.
        send(8'h00, k); send(8'h13, k); send(8'hFF, k);
        pay[0] = 8'h3C; pay[1] = 8'hC3;
        send_frame(8'hFF, 2, 1'b0, 1, k);
        idle(4);

        // Reset in the middle of a four-write burst.
        rand_pay(4);
        send_frame(8'h40, 4, 1'b0, 0, k);
        @(posedge clk);
        #2;
        rst = 1'b1;
        wr_exp.delete();
        @(negedge clk);
        chk("rst_burst_wr_en", wr_en, 0);
        chk("rst_burst_frame_ok", frame_ok, 0);
        chk("rst_burst_busy", busy, 0);
        rst = 1'b0;
        idle(1);
        rand_pay(3);
        send_frame(8'h80, 3, 1'b0, 0, k);
        idle(5);

        // Randomized mix of every frame outcome.
        for (int it = 0; it < 200; it++) begin
            send_noise(int'($urandom_range(2, 0)));
            len  = $urandom_range(16, 1);
            addr = $urandom_range(255, 0);
            rand_pay(len);
            case ($urandom_range(5, 0))
                0, 1: begin
                    send_frame(addr, len, 1'b0, 3, k);
                    idle(len + 2);
                end
                2: send_frame(addr, len, 1'b1, 3, k);
                3: begin
                    if ($urandom_range(1, 0) == 0) send_badlen(8'h00);
                    else send_badlen(8'($urandom_range(255, 17)));
                end
                4: begin
                    p = $urandom_range(len + 2, 0);
                    send(SYNC, k);
                    for (int i = 0; i < p; i++) begin
                        gap(3);
                        if (i == 0) send(addr, k);
                        else if (i == 1) send(8'(len), k);
                        else send(pay[i - 2], k);
                    end
                    er_exp.push_back('{k + T, 2'b11});
                    idle(T + 2);
                end
                default: begin
                    send_frame(addr, len, 1'b0, 3, k);
                    j = $urandom_range(len - 1, 0);
                    idle(j);
                    send(8'($urandom_range(255, 0)), k);
                    er_exp.push_back('{k, 2'b00});
                    idle(len + 2);
                end
            endcase
        end

        for (int w = 0; w < 100; w++) begin
            if (wr_exp.size() == 0 && er_exp.size() == 0) break;
            idle(1);
        end
        chk("wr_queue_drained", wr_exp.size(), 0);
        chk("err_queue_drained", er_exp.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
